useq_fsm: RTL and testbench
===========================

// Module: useq_fsm
// PURPOSE
//  Parametrised microcoded state sequencer: a programmable successor to the fixed 13-state,
//  2-dispatch-table controller. The state register is held internally. Microcode and dispatch
//  ROMs are writable at run time through a config port, with a stall input and an error flag.
//  Sits between the datapath condition signals and the control decode logic.
// PARAMETERS
//  STATE_W  4   state width; NSTATES <= 2**STATE_W
//  NSTATES  13  number of valid states (0..NSTATES-1)
//  COND_W   2   width of condition input y; each dispatch table has 2**COND_W entries
//  NDISP    2   number of dispatch tables; DSEL_W = max(1,$clog2(NDISP))
//  CFG_AW   max(STATE_W, DSEL_W+COND_W), config address width (localparam)
// PORTS
//  clk         in   1            clock, all state changes on posedge
//  rst_n       in   1            asynchronous active-low reset
//  en          in   1            advance state this cycle; 0 = hold (stall)
//  y           in   COND_W       dispatch condition
//  cfg_we      in   1            config write strobe
//  cfg_sel     in   1            0 = microcode ROM, 1 = dispatch ROM
//  cfg_addr    in   CFG_AW       mrom: state index; drom: {table, cond}
//  cfg_data    in   3+STATE_W    mrom word {op[2:0],arg}; drom uses low STATE_W bits
//  state       out  STATE_W      current state (registered)
//  next_state  out  STATE_W      combinational successor of state, for lookahead decode
//  err         out  1            one-cycle pulse: illegal op or out-of-range target
// BEHAVIOUR
//  - Reset (async assert, sync release): state=0, err=0. ROM contents are not reset.
//  - Microcode word mrom[state] = {op,arg}. next_state by op:
//    0 INC   state+1, wraps to 0 when state==NSTATES-1
//    1 DISP  drom[arg[DSEL_W-1:0]][y]; arg>=NDISP -> illegal
//    2 JUMP  arg
//    3 HOLD  state (self-loop regardless of en)
//    4 ZERO  0
//    5..7    illegal
//  - Illegal op, or computed target >= NSTATES: next_state=0. If en=1, err=1 on the following
//    cycle for exactly one cycle; err stays 0 when en=0.
//  - en=1: state<=next_state at posedge (1-cycle latency). en=0: state and err unchanged/0.
//  - Config write takes effect at posedge. A read in the same cycle sees the old contents
//    (write-then-read ordering). Writes are legal while en=1.
//  - cfg_sel=0 with cfg_addr>=NSTATES, or cfg_sel=1 with table>=NDISP: write is ignored.
//  - Reset mid-sequence: state forced to 0 immediately. Programmed ROM contents survive.
//  - y is sampled only in the cycle a DISP op is evaluated. No internal synchroniser.
// STRUCTURE
//  - Package useq_pkg: op enum (OP_INC..OP_ZERO) and word field offsets/width functions.
//  - One sub-module useq_rom: parametrised 1W/1R array with async read. It is instantiated
//    twice (mrom depth NSTATES, drom depth NDISP*2**COND_W).
//  - Top level holds the next-state mux, state register, range check and err register.
// TESTING (defaults; program the legacy table first: 0-2,6-9 INC; 3 DISP t0; 4,5 JUMP 7;
//          10 DISP t1; 11,12 ZERO; t0={4,5,6,6}; t1={11,12,12,12})
//  1 Reset, en=1, y=0 -> state 0,1,2,3,4,7,8,9,10,11,0. err never asserted.
//  2 At state 3 drive y=1 -> 5 then 7. At state 3 drive y=3 -> 6 then 7. At state 10 drive
//    y=2 -> 12 then 0.
//  3 en=0 for 3 cycles at state 5 -> state stays 5. Re-enable -> 7 on next posedge.
//  4 Write mrom[2]={7,0} while in state 1 -> next cycle state 2, then state 0 and a 1-cycle
//    err pulse. Write drom t0[0]=14 -> DISP from 3 yields 0 and err.
//  5 Write mrom[1]={3,0} in the same cycle state is 0 -> 0->1 uses old INC; then HOLD at 1.
//    Deassert rst_n mid-hold -> state 0 asynchronously, ROM still holds HOLD at 1.
//  6 Re-run scenario 1 with NSTATES=16, COND_W=3, NDISP=4 -> INC wraps 15->0. Dispatch on
//    table 3 with y=7 returns the programmed entry.

Source files
------------

// File: rtl/useq_pkg.sv
// Shared definitions for the microcoded sequencer: opcode encoding and
// width helpers used to size the config port and ROM words.
package useq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_INC  = 3'd0,
        OP_DISP = 3'd1,
        OP_JUMP = 3'd2,
        OP_HOLD = 3'd3,
        OP_ZERO = 3'd4
    } op_e;

    function automatic int dsel_w(input int ndisp);
        return (ndisp > 1) ? $clog2(ndisp) : 1;
    endfunction

    function automatic int cfg_aw(input int state_w, input int dsel, input int cond_w);
        return (state_w > dsel + cond_w) ? state_w : dsel + cond_w;
    endfunction

    // Microcode word is {op, arg}
    function automatic int word_w(input int state_w);
        return OP_W + state_w;
    endfunction

endpackage

// File: rtl/useq_rom.sv
// Run-time writable table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so programming survives rst_n.
module useq_rom #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/useq_fsm.sv
// Microcoded state sequencer: the microcode word for the current state picks the
// successor (increment, dispatch on y, jump, hold, zero); bad targets fall back to 0.
module useq_fsm
    import useq_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter int NSTATES  = 13,
    parameter int COND_W   = 2,
    parameter int NDISP    = 2,
    localparam int DSEL_W  = dsel_w(NDISP),
    localparam int CFG_AW  = cfg_aw(STATE_W, DSEL_W, COND_W),
    localparam int WORD_W  = word_w(STATE_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [COND_W-1:0]  y,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [CFG_AW-1:0]  cfg_addr,
    input  logic [WORD_W-1:0]  cfg_data,
    output logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] next_state,
    output logic               err
);

    localparam int DROM_AW = DSEL_W + COND_W;
    localparam int DROM_D  = NDISP << COND_W;

    logic [STATE_W-1:0] state_q, state_d;
    logic               err_q, err_d;
    logic [WORD_W-1:0]  mword;
    logic [STATE_W-1:0] dtgt, arg, tgt;
    logic [DROM_AW-1:0] draddr;
    logic               mrom_we, drom_we, illegal;
    op_e                op;

    // Out-of-range config addresses are dropped rather than aliased into the tables
    assign mrom_we = cfg_we && !cfg_sel && (int'(cfg_addr) < NSTATES);
    assign drom_we = cfg_we &&  cfg_sel && (int'(cfg_addr) < DROM_D);

    useq_rom #(.DEPTH(NSTATES), .AW(STATE_W), .DW(WORD_W)) u_mrom (
        .clk   (clk),
        .we    (mrom_we),
        .waddr (cfg_addr[STATE_W-1:0]),
        .wdata (cfg_data),
        .raddr (state_q),
        .rdata (mword)
    );

    useq_rom #(.DEPTH(DROM_D), .AW(DROM_AW), .DW(STATE_W)) u_drom (
        .clk   (clk),
        .we    (drom_we),
        .waddr (cfg_addr[DROM_AW-1:0]),
        .wdata (cfg_data[STATE_W-1:0]),
        .raddr (draddr),
        .rdata (dtgt)
    );

    assign op     = op_e'(mword[WORD_W-1 -: OP_W]);
    assign arg    = mword[STATE_W-1:0];
    assign draddr = {arg[DSEL_W-1:0], y};

    always_comb begin
        tgt     = '0;
        illegal = 1'b0;
        case (op)
            OP_INC:  tgt = (int'(state_q) == NSTATES - 1) ? '0 : state_q + 1'b1;
            OP_DISP: begin
                tgt     = dtgt;
                illegal = (int'(arg) >= NDISP);
            end
            OP_JUMP: tgt = arg;
            OP_HOLD: tgt = state_q;
            OP_ZERO: tgt = '0;
            default: illegal = 1'b1;
        endcase
        if (int'(tgt) >= NSTATES) illegal = 1'b1;
        state_d = illegal ? '0 : tgt;
        // Error only reported when the bad transition is actually taken
        err_d   = en & illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (en) state_q <= state_d;
            err_q <= err_d;
        end
    end

    assign state      = state_q;
    assign next_state = state_d;
    assign err        = err_q;

endmodule

// File: tb/tb_useq_fsm.sv
// Bench for useq_fsm: reference sequencer model checked every cycle plus directed
// legacy-table scenarios and a wider second instance.
module tb_useq_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en, cfg_we, cfg_sel, err;
    logic [1:0] y;
    logic [3:0] cfg_addr, state, next_state;
    logic [6:0] cfg_data;

    logic       en16, we16, sel16, err16;
    logic [2:0] y16;
    logic [4:0] addr16;
    logic [6:0] data16;
    logic [3:0] st16, ns16;

    useq_fsm dut (
        .clk(clk), .rst_n(rst_n), .en(en), .y(y), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .state(state), .next_state(next_state), .err(err)
    );

    useq_fsm #(.STATE_W(4), .NSTATES(16), .COND_W(3), .NDISP(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en16), .y(y16), .cfg_we(we16), .cfg_sel(sel16),
        .cfg_addr(addr16), .cfg_data(data16), .state(st16), .next_state(ns16), .err(err16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    int MW [13] = '{'h00, 'h00, 'h00, 'h10, 'h27, 'h27, 'h00, 'h00, 'h00, 'h00, 'h11, 'h40, 'h40};
    int DT [8]  = '{4, 5, 6, 6, 11, 12, 12, 12};

    // Reference model: op/arg tables, dispatch table, current state and pending err
    int m_op [13];
    int m_arg [13];
    int d_tbl [8];
    int ms = 0;
    int me = 0;

    // Successor per the sequencing rules; -1 marks an illegal transition
    function automatic int model_next(input int s, input int yy);
        int t;
        t = 0;
        case (m_op[s])
            0: t = (s == 12) ? 0 : s + 1;
            1: begin
                if (m_arg[s] >= 2) return -1;
                t = d_tbl[m_arg[s] * 4 + yy];
            end
            2: t = m_arg[s];
            3: t = s;
            4: t = 0;
            default: return -1;
        endcase
        return (t >= 13) ? -1 : t;
    endfunction

    function automatic int nz(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms <= 0;
            me <= 0;
        end else begin
            if (en) ms <= nz(model_next(ms, int'(y)));
            me <= (en && model_next(ms, int'(y)) < 0) ? 1 : 0;
            if (cfg_we && !cfg_sel && cfg_addr < 13) begin
                m_op[cfg_addr]  <= int'(cfg_data[6:4]);
                m_arg[cfg_addr] <= int'(cfg_data[3:0]);
            end else if (cfg_we && cfg_sel && cfg_addr < 8) begin
                d_tbl[cfg_addr] <= int'(cfg_data[3:0]);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            chk("cyc_state", int'(state), ms);
            chk("cyc_next_state", int'(next_state), nz(model_next(ms, int'(y))));
            chk("cyc_err", int'(err), me);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input int yy, input int exp, input string nm);
        y = 2'(yy);
        tick();
        chk(nm, int'(state), exp);
    endtask

    task automatic cfg(input bit sel, input int addr, input int data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 4'(addr); cfg_data = 7'(data);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int E1 [10] = '{1, 2, 3, 4, 7, 8, 9, 10, 11, 0};
    int S2Y [15] = '{0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 3, 0};
    int S2E [15] = '{1, 2, 3, 5, 7, 8, 9, 10, 12, 0, 1, 2, 3, 6, 7};
    int E6 [13] = '{1, 2, 3, 4, 5, 9, 10, 11, 12, 13, 14, 15, 0};

    initial begin
        en = 0; y = 0; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_data = 0;
        en16 = 0; y16 = 0; we16 = 0; sel16 = 0; addr16 = 0; data16 = 0;
        #12;
        chk("reset_state", int'(state), 0);
        chk("reset_err", int'(err), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) cfg(1'b0, i, MW[i]);
        for (int i = 0; i < 8; i++) cfg(1'b1, i, DT[i]);
        // table index 2 does not exist: must not alias onto t0[0]
        cfg(1'b1, 8, 14);
        chk_on = 1'b1;

        // legacy walk with y=0
        en = 1'b1;
        chk("s1_start", int'(state), 0);
        for (int i = 0; i < 10; i++) step(0, E1[i], "s1_seq");

        // dispatch variants
        for (int i = 0; i < 15; i++) step(S2Y[i], S2E[i], "s2_disp");

        // stall at state 5
        do_reset();
        step(0, 1, "s3_pre"); step(0, 2, "s3_pre"); step(0, 3, "s3_pre"); step(1, 5, "s3_pre");
        en = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 5, "s3_stall");
        en = 1'b1;
        step(0, 7, "s3_resume");
        chk("s3_err", int'(err), 0);

        // illegal op written while running
        do_reset();
        step(0, 1, "s4_pre");
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd2; cfg_data = 7'h70;
        tick();
        cfg_we = 1'b0;
        chk("s4_state2", int'(state), 2);
        chk("s4_err_lo", int'(err), 0);
        en = 1'b0;
        step(0, 2, "s4_stall");
        chk("s4_stall_err", int'(err), 0);
        chk("s4_ns_zero", int'(next_state), 0);
        en = 1'b1;
        step(0, 0, "s4_bad_op");
        chk("s4_err_pulse", int'(err), 1);
        step(0, 1, "s4_after");
        chk("s4_err_clear", int'(err), 0);
        en = 1'b0;
        cfg(1'b0, 2, 'h00);
        cfg(1'b1, 0, 14);
        en = 1'b1;
        step(0, 2, "s4_pre2"); step(0, 3, "s4_pre2");
        step(0, 0, "s4_bad_tgt");
        chk("s4_tgt_err", int'(err), 1);
        step(0, 1, "s4_after2");
        chk("s4_tgt_clear", int'(err), 0);
        en = 1'b0;
        cfg(1'b1, 0, 4);

        // write-then-read ordering, HOLD, async reset
        do_reset();
        en = 1'b1;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd1; cfg_data = 7'h30;
        tick();
        cfg_we = 1'b0;
        chk("s5_old_inc", int'(state), 1);
        step(0, 1, "s5_hold"); step(0, 1, "s5_hold");
        #1 rst_n = 1'b0;
        #1 chk("s5_async_rst", int'(state), 0);
        tick();
        rst_n = 1'b1;
        step(0, 1, "s5_rerun"); step(0, 1, "s5_rom_kept");
        en = 1'b0;
        cfg(1'b0, 1, 'h00);

        // wider instance: 16 states, 4 tables, 3-bit y
        for (int i = 0; i < 16; i++) begin
            we16 = 1'b1; sel16 = 1'b0; addr16 = 5'(i); data16 = (i == 5) ? 7'h13 : 7'h00;
            tick();
        end
        sel16 = 1'b1; addr16 = 5'd31; data16 = 7'd9;
        tick();
        we16 = 1'b0;
        en16 = 1'b1; y16 = 3'd7;
        chk("s6_start", int'(st16), 0);
        for (int i = 0; i < 13; i++) begin
            chk("s6_ns", int'(ns16), E6[i]);
            tick();
            chk("s6_seq", int'(st16), E6[i]);
        end
        chk("s6_err", int'(err16), 0);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
